sisc_ifetch: RTL and testbench
==============================

SISC_IFETCH -- requirements
Module: sisc_ifetch

Interface
REQ-001 Parameter AW, default 16, SHALL set the instruction address width.
REQ-002 Parameter DW, default 32, SHALL set the instruction word width.
REQ-003 Parameter TMO, default 255, SHALL set the ack-wait limit in cycles; it is used only when SISC_IFETCH_TIMEOUT_EN is defined.
REQ-004 clk  in  1  SHALL be the clock; all state changes occur on its rising edge.
REQ-005 rst_f  in  1  SHALL be the reset: asynchronous, active-low.
REQ-006 fetch_go  in  1  SHALL be the single-cycle fetch request from the control FSM.
REQ-007 br_take  in  1  SHALL be the single-cycle branch-taken strobe.
REQ-008 br_rel  in  1  SHALL select the branch mode: 1 = relative, 0 = absolute.
REQ-009 br_addr  in  AW  SHALL carry the branch target (absolute) or offset (relative, two's complement).
REQ-010 imem_req  out  1  SHALL be the instruction-memory request.
REQ-011 imem_addr  out  AW  SHALL be the fetch address; it equals pc.
REQ-012 imem_ack  in  1  SHALL be the memory acknowledge; imem_rdata is valid in the same cycle.
REQ-013 imem_rdata  in  DW  SHALL carry the instruction word.
REQ-014 ir  out  DW  SHALL hold the instruction register.
REQ-015 opcode  out  4 and mm  out  4 SHALL equal ir[31:28] and ir[27:24] respectively.
REQ-016 ir_valid  out  1  SHALL pulse for one cycle when a new ir is loaded.
REQ-017 pc  out  AW  SHALL hold the program counter.
REQ-018 busy  out  1  SHALL be high in every state except IDLE.
REQ-019 halted  out  1  SHALL be high in the HALTED state.
REQ-020 fetch_err  out  1  SHALL be the sticky timeout flag; it is tied to 0 when the macro is undefined.

Function
REQ-021 The FSM SHALL have four states:
- IDLE: fetch_go -> REQ.
- REQ: imem_req=1; imem_ack -> LOAD.
- LOAD: ir_valid=1 -> IDLE, or -> HALTED if opcode==4'hF.
- HALTED: absorbing until reset.
REQ-022 In REQ, imem_req and imem_addr SHALL stay stable until imem_ack is sampled high.
REQ-023 On the edge where imem_ack is sampled high in REQ, the block SHALL load ir from imem_rdata and set pc to pc+1, wrapping modulo 2^AW.
REQ-024 imem_req SHALL be low from the cycle after ack onward.
REQ-025 Latency with a zero-wait memory SHALL be: fetch_go in cycle 0, imem_req in cycle 1, ack in cycle 1, ir_valid in cycle 2, IDLE in cycle 3.
REQ-026 br_take SHALL be honoured in IDLE and LOAD:
- absolute: pc <= br_addr;
- relative: pc <= pc + br_addr, modulo 2^AW.
REQ-027 In LOAD, a branch SHALL override the pc+1 written at capture, using the already-incremented pc as base.
REQ-028 br_take in REQ or HALTED SHALL be ignored.
REQ-029 If fetch_go and br_take occur together in IDLE, pc SHALL take the branch target and the following REQ SHALL present that target on imem_addr.
REQ-030 fetch_go outside IDLE SHALL be ignored; it is not queued.
REQ-031 imem_ack outside REQ SHALL be ignored.
REQ-032 A HLT word SHALL still load ir and pulse ir_valid before the FSM enters HALTED.
REQ-033 In HALTED, all inputs except rst_f SHALL be ignored and imem_req SHALL stay 0.

Reset
REQ-034 rst_f low SHALL immediately force: state IDLE, pc=0, ir=0, imem_req=0, ir_valid=0, halted=0, fetch_err=0, timeout counter=0.
REQ-035 A reset during REQ SHALL abandon the access; an ack arriving after reset release SHALL be ignored under REQ-031.
REQ-036 The first fetch after reset release SHALL use address 0.

Configuration
REQ-037 With SISC_IFETCH_TIMEOUT_EN defined:
- an 8-bit counter SHALL clear on entry to REQ and increment each REQ cycle without ack;
- on reaching TMO, the block SHALL drop imem_req, set fetch_err, and enter HALTED;
- ir and pc SHALL remain unchanged.
REQ-038 With SISC_IFETCH_TIMEOUT_EN undefined, the block SHALL have no counter, REQ SHALL wait indefinitely, and fetch_err SHALL be constant 0.

Structure
REQ-039 Package sisc_pkg SHALL hold:
- opcode constants (NOOP=0, LOD=1, STR=2, SWP=3, BRA=4, BRR=5, BNE=6, BNR=7, ALU_OP=8, HLT=15);
- the AM_IMM=8 constant;
- field bit positions;
- the fetch-state enum.
REQ-040 The sub-module sisc_pc SHALL contain the pc register and the next-pc mux/adder (hold, +1, absolute, relative).

Verification
REQ-041 Zero-wait fetch: reset, fetch_go, ack in the first REQ cycle with rdata=32'h8100_0003 -> ir_valid in cycle 2, opcode=8, mm=1, pc=1.
REQ-042 Wait states: ack delayed 5 cycles -> imem_req high for 6 cycles with addr constant, single ir_valid pulse.
REQ-043 Branches:
- relative, pc=16'h0001 with br_addr=16'hFFFF -> pc=0;
- absolute 16'h0040 together with fetch_go in IDLE -> imem_addr=16'h0040.
REQ-044 HLT and ignored inputs: rdata=32'hF000_0000 -> ir_valid, then halted=1; further fetch_go and br_take leave imem_req=0 and pc unchanged.
REQ-045 Reset mid-REQ: rst_f low during REQ -> imem_req=0 immediately, pc=0; a late ack produces no ir_valid.
REQ-046 With macro defined and TMO=4, no ack -> imem_req drops after 4 REQ cycles, fetch_err=1, halted=1; with macro undefined, req stays high indefinitely.

Source files
------------

// File: rtl/sisc_pkg.sv
// sisc_pkg: shared constants and types for the SISC fetch unit.
// Instruction opcodes, addressing-mode constant, instruction field positions,
// the fetch FSM state encoding and the next-pc select encoding.
package sisc_pkg;
  localparam logic [3:0] OP_NOOP   = 4'h0;
  localparam logic [3:0] OP_LOD    = 4'h1;
  localparam logic [3:0] OP_STR    = 4'h2;
  localparam logic [3:0] OP_SWP    = 4'h3;
  localparam logic [3:0] OP_BRA    = 4'h4;
  localparam logic [3:0] OP_BRR    = 4'h5;
  localparam logic [3:0] OP_BNE    = 4'h6;
  localparam logic [3:0] OP_BNR    = 4'h7;
  localparam logic [3:0] OP_ALU_OP = 4'h8;
  localparam logic [3:0] OP_HLT    = 4'hF;

  localparam logic [3:0] AM_IMM    = 4'h8;

  // Instruction field bit positions
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 28;
  localparam int MM_HI  = 27;
  localparam int MM_LO  = 24;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_LOAD   = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_HOLD = 2'd0,
    PC_INC  = 2'd1,
    PC_ABS  = 2'd2,
    PC_REL  = 2'd3
  } pc_sel_e;
endpackage

// File: rtl/sisc_pc.sv
// sisc_pc: program counter register with its next-pc mux/adder
// (hold, +1, absolute load, relative add). All arithmetic wraps mod 2^AW.
module sisc_pc
  import sisc_pkg::*;
#(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst_f,
  input  pc_sel_e       sel,
  input  logic [AW-1:0] br_addr,
  output logic [AW-1:0] pc
);
  localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

  logic [AW-1:0] pc_d, pc_q;

  // Select the next program counter value
  always_comb begin
    pc_d = pc_q;
    case (sel)
      PC_INC:  pc_d = pc_q + ONE;
      PC_ABS:  pc_d = br_addr;
      PC_REL:  pc_d = pc_q + br_addr;
      default: pc_d = pc_q;
    endcase
  end

  // Program counter register, cleared asynchronously
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) pc_q <= '0;
    else        pc_q <= pc_d;
  end

  assign pc = pc_q;
endmodule

// File: rtl/sisc_ifetch.sv
// sisc_ifetch: instruction fetch FSM (IDLE -> REQ -> LOAD -> IDLE/HALTED).
// Issues one instruction-memory request per fetch_go, captures the word into
// ir and advances pc on ack; branches are taken in IDLE and LOAD.
// Optional feature: define SISC_IFETCH_TIMEOUT_EN to add an ack-wait
// counter that halts the fetcher with fetch_err after TMO cycles.
module sisc_ifetch
  import sisc_pkg::*;
#(
  parameter int AW  = 16,
  parameter int DW  = 32,
  parameter int TMO = 255
) (
  input  logic          clk,
  input  logic          rst_f,
  input  logic          fetch_go,
  input  logic          br_take,
  input  logic          br_rel,
  input  logic [AW-1:0] br_addr,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [DW-1:0] imem_rdata,
  output logic [DW-1:0] ir,
  output logic [3:0]    opcode,
  output logic [3:0]    mm,
  output logic          ir_valid,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          halted,
  output logic          fetch_err
);
  fetch_state_e  state_d, state_q;
  logic [DW-1:0] ir_d, ir_q;
  logic          req_d, req_q, vld_d, vld_q, busy_d, busy_q, hlt_d, hlt_q;
  pc_sel_e       pc_sel, br_sel;

`ifdef SISC_IFETCH_TIMEOUT_EN
  localparam logic [7:0] TMO_C = 8'(TMO);
  logic [7:0] cnt_d, cnt_q;
  logic       err_d, err_q;
`endif

  // Next-state, capture and pc-select decisions for the fetch FSM
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    pc_sel  = PC_HOLD;
    br_sel  = br_rel ? PC_REL : PC_ABS;
`ifdef SISC_IFETCH_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (br_take) pc_sel = br_sel;
        if (fetch_go) begin
          state_d = ST_REQ;
`ifdef SISC_IFETCH_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ST_REQ: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          pc_sel  = PC_INC;
          state_d = ST_LOAD;
        end
`ifdef SISC_IFETCH_TIMEOUT_EN
        else if (cnt_q + 8'd1 == TMO_C) begin
          state_d = ST_HALTED;
          err_d   = 1'b1;
        end else begin
          cnt_d   = cnt_q + 8'd1;
        end
`endif
      end
      ST_LOAD: begin
        // Branch base is the pc already incremented at capture
        if (br_take) pc_sel = br_sel;
        state_d = (ir_q[OPC_HI:OPC_LO] == OP_HLT) ? ST_HALTED : ST_IDLE;
      end
      default: ;
    endcase
    req_d  = (state_d == ST_REQ);
    vld_d  = (state_d == ST_LOAD);
    busy_d = (state_d != ST_IDLE);
    hlt_d  = (state_d == ST_HALTED);
  end

  // FSM state, instruction register and registered status outputs
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q <= ST_IDLE;
      ir_q    <= '0;
      req_q   <= 1'b0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      hlt_q   <= 1'b0;
`ifdef SISC_IFETCH_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      req_q   <= req_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      hlt_q   <= hlt_d;
`ifdef SISC_IFETCH_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  sisc_pc #(.AW(AW)) u_pc (
    .clk     (clk),
    .rst_f   (rst_f),
    .sel     (pc_sel),
    .br_addr (br_addr),
    .pc      (pc)
  );

  assign imem_req  = req_q;
  assign imem_addr = pc;
  assign ir        = ir_q;
  assign opcode    = ir_q[OPC_HI:OPC_LO];
  assign mm        = ir_q[MM_HI:MM_LO];
  assign ir_valid  = vld_q;
  assign busy      = busy_q;
  assign halted    = hlt_q;
`ifdef SISC_IFETCH_TIMEOUT_EN
  assign fetch_err = err_q;
`else
  assign fetch_err = 1'b0;
`endif
endmodule

// File: tb/tb_sisc_ifetch.sv
// tb_sisc_ifetch: directed scenarios plus randomized traffic for sisc_ifetch,
// checked every cycle against a transaction-level reference model.
module tb_sisc_ifetch;
  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int TMO = 4;
  localparam int MOD = 1 << AW;

  logic          clk = 1'b0, rst_f = 1'b0;
  logic          fetch_go = 1'b0, br_take = 1'b0, br_rel = 1'b0, imem_ack = 1'b0;
  logic [AW-1:0] br_addr = '0;
  logic [DW-1:0] imem_rdata = '0;
  logic          imem_req, ir_valid, busy, halted, fetch_err;
  logic [AW-1:0] imem_addr, pc;
  logic [DW-1:0] ir;
  logic [3:0]    opcode, mm;

  sisc_ifetch #(.AW(AW), .DW(DW), .TMO(TMO)) dut (
    .clk(clk), .rst_f(rst_f), .fetch_go(fetch_go), .br_take(br_take),
    .br_rel(br_rel), .br_addr(br_addr), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ir(ir), .opcode(opcode), .mm(mm), .ir_valid(ir_valid), .pc(pc),
    .busy(busy), .halted(halted), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // Reference model: 0 waiting for go, 1 memory access open, 2 word just
  // delivered, 3 stopped
  int          m_st, m_pc, m_wait;
  logic [31:0] m_ir;
  bit          m_err;

`ifdef SISC_IFETCH_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cmp_all(input string t);
    chk({t, "_req"},    32'(imem_req),  32'(m_st == 1));
    chk({t, "_addr"},   32'(imem_addr), 32'(m_pc));
    chk({t, "_pc"},     32'(pc),        32'(m_pc));
    chk({t, "_ir"},     ir,             m_ir);
    chk({t, "_opc"},    32'(opcode),    32'(m_ir[31:28]));
    chk({t, "_mm"},     32'(mm),        32'(m_ir[27:24]));
    chk({t, "_vld"},    32'(ir_valid),  32'(m_st == 2));
    chk({t, "_busy"},   32'(busy),      32'(m_st != 0));
    chk({t, "_halted"}, 32'(halted),    32'(m_st == 3));
    chk({t, "_err"},    32'(fetch_err), 32'(m_err));
  endtask

  function automatic int br_tgt(input int base);
    return br_rel ? (base + int'(br_addr)) % MOD : int'(br_addr);
  endfunction

  // Advance the model by one clock using the inputs currently driven
  task automatic model_step();
    case (m_st)
      0: begin
        if (br_take) m_pc = br_tgt(m_pc);
        if (fetch_go) begin m_st = 1; m_wait = 0; end
      end
      1: begin
        if (imem_ack) begin
          m_ir = imem_rdata;
          m_pc = (m_pc + 1) % MOD;
          m_st = 2;
        end else if (TMO_ON) begin
          m_wait++;
          if (m_wait == TMO) begin m_st = 3; m_err = 1'b1; end
        end
      end
      2: begin
        if (br_take) m_pc = br_tgt(m_pc);
        m_st = (m_ir[31:28] == 4'hF) ? 3 : 0;
      end
      default: ;
    endcase
  endtask

  task automatic cyc(input bit go, input bit bt, input bit rel, input logic [15:0] ba,
                     input bit ack, input logic [31:0] rd, input string t);
    fetch_go = go; br_take = bt; br_rel = rel; br_addr = ba;
    imem_ack = ack; imem_rdata = rd;
    model_step();
    @(posedge clk); #1;
    cmp_all(t);
  endtask

  task automatic do_reset(input string t);
    rst_f = 1'b0;
    fetch_go = 0; br_take = 0; br_rel = 0; br_addr = '0; imem_ack = 0; imem_rdata = '0;
    #1;
    m_st = 0; m_pc = 0; m_ir = '0; m_err = 1'b0; m_wait = 0;
    cmp_all(t);
    @(posedge clk); #1;
    rst_f = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  int n, waits;
  logic [15:0] a0;
  logic [31:0] rd;

  initial begin
    #1;
    do_reset("rst");

    // Zero-wait fetch
    cyc(1, 0, 0, 0, 0, 0, "zw_go");
    chk("zw_req1", 32'(imem_req), 1);
    cyc(0, 0, 0, 0, 1, 32'h8100_0003, "zw_ack");
    chk("zw_vld2", 32'(ir_valid), 1);
    chk("zw_opc8", 32'(opcode), 8);
    chk("zw_mm1",  32'(mm), 1);
    chk("zw_pc1",  32'(pc), 1);
    cyc(0, 0, 0, 0, 0, 0, "zw_idle");
    chk("zw_idle3", 32'(busy), 0);

    // Wait states: request and address held until ack
    do_reset("ws_rst");
    waits = TMO_ON ? 2 : 5;
    n = 0;
    cyc(1, 0, 0, 0, 0, 0, "ws_go");
    a0 = imem_addr;
    if (imem_req) n++;
    for (int i = 0; i < waits; i++) begin
      cyc(0, 1, 1, 16'h0010, 0, 0, "ws_wait");
      if (imem_req) n++;
      chk("ws_addr_hold", 32'(imem_addr), 32'(a0));
    end
    cyc(0, 0, 0, 0, 1, 32'h2300_1234, "ws_ack");
    chk("ws_req_cnt", n, waits + 1);
    n = ir_valid ? 1 : 0;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 1, 32'h1111_1111, "ws_post");
      if (ir_valid) n++;
    end
    chk("ws_vld_cnt", n, 1);

    // Branches: relative wrap, absolute with go
    do_reset("br_rst");
    cyc(1, 0, 0, 0, 0, 0, "br_go");
    cyc(0, 0, 0, 0, 1, 32'h0000_0000, "br_ack");
    cyc(0, 0, 0, 0, 0, 0, "br_idle");
    chk("br_pc_pre", 32'(pc), 1);
    cyc(0, 1, 1, 16'hFFFF, 0, 0, "br_rel");
    chk("br_rel_pc0", 32'(pc), 0);
    cyc(1, 1, 0, 16'h0040, 0, 0, "br_abs");
    chk("br_abs_addr", 32'(imem_addr), 32'h0040);
    chk("br_abs_req", 32'(imem_req), 1);
    cyc(0, 0, 0, 0, 1, 32'h4000_0000, "br_ack2");
    cyc(0, 1, 1, 16'h0003, 0, 0, "br_load_rel");
    chk("br_load_pc", 32'(pc), 32'h0044);

    // HLT word loads, then everything is ignored
    do_reset("hlt_rst");
    cyc(1, 0, 0, 0, 0, 0, "hlt_go");
    cyc(0, 0, 0, 0, 1, 32'hF000_0000, "hlt_ack");
    chk("hlt_vld", 32'(ir_valid), 1);
    cyc(0, 0, 0, 0, 0, 0, "hlt_enter");
    chk("hlt_halted", 32'(halted), 1);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1, i[0], 16'h0077, 1, 32'h8000_0000, "hlt_ign");
      chk("hlt_req0", 32'(imem_req), 0);
      chk("hlt_pc_keep", 32'(pc), 1);
    end

    // Reset in the middle of an access
    do_reset("mr_rst");
    cyc(1, 0, 0, 0, 0, 0, "mr_go1");
    cyc(0, 0, 0, 0, 1, 32'h1000_0000, "mr_ack1");
    cyc(0, 0, 0, 0, 0, 0, "mr_idle");
    cyc(1, 0, 0, 0, 0, 0, "mr_go2");
    chk("mr_in_req", 32'(imem_req), 1);
    rst_f = 1'b0;
    #1;
    chk("mr_req_drop", 32'(imem_req), 0);
    chk("mr_pc0", 32'(pc), 0);
    m_st = 0; m_pc = 0; m_ir = '0; m_err = 1'b0;
    @(posedge clk); #1;
    rst_f = 1'b1;
    cyc(0, 0, 0, 0, 1, 32'h2000_0000, "mr_late_ack");
    chk("mr_no_vld", 32'(ir_valid), 0);
    cyc(0, 0, 0, 0, 1, 32'h2000_0000, "mr_late_ack2");
    chk("mr_no_vld2", 32'(ir_valid), 0);

    // No ack at all
    do_reset("to_rst");
    n = 0;
    cyc(1, 0, 0, 0, 0, 0, "to_go");
    if (imem_req) n++;
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0, 0, 0, 0, 0, "to_wait");
      if (imem_req) n++;
    end
    chk("to_req_cnt", n, TMO_ON ? TMO : 21);
    chk("to_err", 32'(fetch_err), 32'(TMO_ON));
    chk("to_halted", 32'(halted), 32'(TMO_ON));

    // Randomized traffic
    do_reset("rnd_rst");
    for (int i = 0; i < 3000; i++) begin
      if (m_st == 3 || $urandom_range(0, 99) == 0) do_reset("rnd_rst");
      rd = $urandom;
      if ($urandom_range(0, 9) == 0) rd[31:28] = 4'hF;
      else rd[31:28] = 4'($urandom_range(0, 14));
      cyc($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, 1'($urandom),
          16'($urandom), 1'($urandom), rd, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
